// File: rtl/multicycle_core_pkg.sv
// Shared types, opcode encodings and the funct3-to-ALU-op mapping for multicycle_core.
package multicycle_core_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} core_state_t;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // alt selects SUB over ADD and SRA over SRL; callers decide when alt is meaningful.
    function automatic alu_op_t f3_to_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_core_alu.sv
// Combinational RV32I integer ALU shared by all execute work in multicycle_core.
module core_alu
    import multicycle_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         op,
    output logic [XLEN-1:0] y
);
    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $signed(a) >>> shamt;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I core (OP, OP-IMM, LUI) with handshake fetch and one shared ALU.
// Define MULTICYCLE_CORE_BRANCH_EN to add BEQ/BNE/BLT/BGE/BLTU/BGEU and JAL.
module multicycle_core
    import multicycle_core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     retire,
    output logic [XLEN-1:0]          retire_pc,
    output logic                     halted,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [XLEN-1:0]          dbg_data
);
    localparam int AW = $clog2(NREGS);
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    if (XLEN != 32) begin : g_xlen_chk
        $error("multicycle_core: XLEN must be 32");
    end
    if (NREGS != 32 && NREGS != 16) begin : g_nregs_chk
        $error("multicycle_core: NREGS must be 16 or 32");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_pc_chk
        $error("multicycle_core: RESET_PC must be 4-byte aligned");
    end

    core_state_t     state;
    logic [XLEN-1:0] pc, op_a, op_b, res, target;
    logic [31:0]     ir;
    alu_op_t         alu_op;
    logic            wr_en, is_br, is_jal, br_inv, take;
    logic [XLEN-1:0] regs [NREGS];

    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    logic [XLEN-1:0] rs1_val, rs2_val, i_imm, u_imm, b_imm, j_imm;
    assign rs1_val = regs[rs1[AW-1:0]];
    assign rs2_val = regs[rs2[AW-1:0]];
    assign i_imm   = {{20{ir[31]}}, ir[31:20]};
    assign u_imm   = {ir[31:12], 12'b0};
    assign b_imm   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign j_imm   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    logic            d_ill, d_wr, d_br, d_jal, d_inv, d_use1, d_use2, d_userd;
    logic [XLEN-1:0] d_a, d_b, d_tgt;
    alu_op_t         d_op;

    always_comb begin
        d_ill = 1'b0;  d_wr = 1'b0;  d_br = 1'b0;  d_jal = 1'b0;  d_inv = 1'b0;
        d_use1 = 1'b0; d_use2 = 1'b0; d_userd = 1'b0;
        d_a = rs1_val; d_b = i_imm;  d_op = ALU_ADD;
        d_tgt = pc + ((opcode == JAL) ? j_imm : b_imm);
        case (opcode)
            OP: begin
                d_b = rs2_val; d_op = f3_to_op(f3, f7 == F7_ALT);
                d_wr = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1; d_userd = 1'b1;
                d_ill = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OP_IMM: begin
                d_op = f3_to_op(f3, f3 == 3'b101 && f7 == F7_ALT);
                d_wr = 1'b1; d_use1 = 1'b1; d_userd = 1'b1;
                if (f3 == 3'b001)      d_ill = (f7 != F7_BASE);
                else if (f3 == 3'b101) d_ill = !(f7 == F7_BASE || f7 == F7_ALT);
            end
            LUI: begin
                d_a = '0; d_b = u_imm; d_wr = 1'b1; d_userd = 1'b1;
            end
`ifdef MULTICYCLE_CORE_BRANCH_EN
            // Branch compares reuse the ALU: SUB for equality, SLT/SLTU for ordering.
            BRANCH: begin
                d_b = rs2_val; d_br = 1'b1; d_inv = f3[0]; d_use1 = 1'b1; d_use2 = 1'b1;
                case (f3[2:1])
                    2'b00:   d_op = ALU_SUB;
                    2'b10:   d_op = ALU_SLT;
                    2'b11:   d_op = ALU_SLTU;
                    default: d_ill = 1'b1;
                endcase
            end
            JAL: begin
                d_a = pc; d_b = XLEN'(4); d_wr = 1'b1; d_jal = 1'b1; d_userd = 1'b1;
            end
`endif
            default: d_ill = 1'b1;
        endcase
        if ((d_use1 && {1'b0, rs1} >= NREGS_L) || (d_use2 && {1'b0, rs2} >= NREGS_L) ||
            (d_userd && {1'b0, rd} >= NREGS_L))
            d_ill = 1'b1;
    end

    logic [XLEN-1:0] alu_y;
    logic            ex_take;

    core_alu #(.XLEN(XLEN)) u_alu (.a(op_a), .b(op_b), .op(alu_op), .y(alu_y));

    assign ex_take = is_jal ||
        (is_br && (br_inv ^ ((alu_op == ALU_SUB) ? (alu_y == '0) : alu_y[0])));

    // Gated by reset so the request drops the instant reset asserts.
    assign imem_req  = (state == FETCH) && reset;
    assign imem_addr = pc;
    assign dbg_data  = regs[dbg_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;  pc <= RESET_PC; ir <= '0;
            op_a <= '0;      op_b <= '0;     alu_op <= ALU_ADD; res <= '0;
            wr_en <= 1'b0;   is_br <= 1'b0;  is_jal <= 1'b0;    br_inv <= 1'b0;
            target <= '0;    take <= 1'b0;
            retire <= 1'b0;  retire_pc <= '0; halted <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                FETCH: if (imem_ack) begin
                    ir    <= imem_rdata;
                    state <= DECODE;
                end
                DECODE: if (d_ill) begin
                    halted <= 1'b1;
                    state  <= HALT;
                end else begin
                    op_a <= d_a;  op_b <= d_b;   alu_op <= d_op;  wr_en <= d_wr;
                    is_br <= d_br; is_jal <= d_jal; br_inv <= d_inv; target <= d_tgt;
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    res <= alu_y;
                    // A misaligned taken target stops the core with the PC left on the branch.
                    if (ex_take && target[1:0] != 2'b00) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        take      <= ex_take;
                        retire    <= 1'b1;
                        retire_pc <= pc;
                        state     <= WRITEBACK;
                    end
                end
                WRITEBACK: begin
                    if (wr_en && rd != 5'd0) regs[rd[AW-1:0]] <= res;
                    pc    <= take ? target : pc + XLEN'(4);
                    state <= FETCH;
                end
                default: halted <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: directed programs, queued retire expectations.
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, retire, halted;
    logic [31:0] imem_addr, imem_rdata, retire_pc, dbg_data;
    logic [4:0]  dbg_addr;

    logic        req16, ack16, retire16, halted16;
    logic [31:0] addr16, rdata16, rpc16, dbgd16;
    logic [3:0]  dbg16;

    always #5 clk = ~clk;

    multicycle_core #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .retire(retire),
        .retire_pc(retire_pc), .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data));

    multicycle_core #(.XLEN(32), .NREGS(16), .RESET_PC(32'h0)) dut16 (
        .clk(clk), .reset(reset), .imem_req(req16), .imem_addr(addr16),
        .imem_ack(ack16), .imem_rdata(rdata16), .retire(retire16),
        .retire_pc(rpc16), .halted(halted16), .dbg_addr(dbg16), .dbg_data(dbgd16));

    int total = 0;
    int bad   = 0;
    int cyc;
    int delay = 0;
    logic [31:0] mem [64];

    typedef struct { logic [31:0] pc; int cyc; } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    // Cycle k after reset release reads cyc == k at its falling edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 1;
        else        cyc <= cyc + 1;
    end

    // Instruction memory: ack after 'delay' waiting cycles; ack stays high outside fetch when delay is 0.
    initial begin
        int          wcnt;
        logic [31:0] held;
        wcnt = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (wcnt > 0) chk("addr_stable", imem_addr, held);
                else          held = imem_addr;
                if (wcnt >= delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr[7:2]];
                    wcnt       = 0;
                end else begin
                    imem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                if (wcnt > 0 && reset) begin
                    total++; bad++;
                    $display("FAIL req_held: request dropped after %0d wait cycles", wcnt);
                end
                imem_ack = (delay == 0);
                wcnt     = 0;
            end
        end
    end

    // Retire monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (reset && retire) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_retire: pc %h with nothing expected", retire_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("retire_pc", retire_pc, e.pc);
                chk("retire_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
        if (reset) chk("rv16_no_retire", 32'(retire16), 32'd0);
    end

    task automatic hold_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    task automatic release_reset();
        reset = 1'b1;
    endtask

    task automatic expect_retire(input logic [31:0] pc, input int c);
        exp_t e;
        e.pc  = pc;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic rd_reg(input logic [4:0] r, input logic [31:0] exp);
        dbg_addr = r;
        #1;
        chk($sformatf("x%0d", r), dbg_data, exp);
    endtask

    task automatic load_t1();
        mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd5);
        mem[1] = enc_i(12'd7, 5'd0, 3'b000, 5'd6);
        mem[2] = enc_r(7'b0, 5'd5, 5'd6, 3'b000, 5'd7);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        dbg_addr   = '0;
        dbg16      = '0;
        ack16      = 1'b1;
        rdata16    = enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd20);

        // 1: three-instruction program, ack tied high, 4 cycles each
        hold_reset();
        load_t1();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retire_pc", retire_pc, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        rd_reg(5'd7, 32'd0);
        expect_retire(32'd0, 4);
        expect_retire(32'd4, 8);
        expect_retire(32'd8, 12);
        release_reset();
        @(negedge clk);
        chk("first_req", 32'(imem_req), 32'd1);
        wait_drain(100);
        rd_reg(5'd5, 32'd5);
        rd_reg(5'd6, 32'd7);
        rd_reg(5'd7, 32'd12);
        wait_cyc(16);
        chk("t1_halted", 32'(halted), 32'd1);
        chk("t1_halt_req", 32'(imem_req), 32'd0);

        // 2: SUB/SLT/SLTU and logic/shift ops
        hold_reset();
        mem[0] = enc_i(12'd3, 5'd0, 3'b000, 5'd9);
        mem[1] = enc_i(12'd5, 5'd0, 3'b000, 5'd8);
        mem[2] = enc_r(7'b0100000, 5'd8, 5'd9, 3'b000, 5'd10);
        mem[3] = enc_r(7'b0, 5'd0, 5'd10, 3'b010, 5'd11);
        mem[4] = enc_r(7'b0, 5'd0, 5'd10, 3'b011, 5'd12);
        mem[5] = enc_r(7'b0, 5'd8, 5'd9, 3'b100, 5'd13);
        mem[6] = enc_r(7'b0, 5'd8, 5'd9, 3'b110, 5'd14);
        mem[7] = enc_r(7'b0, 5'd8, 5'd9, 3'b111, 5'd15);
        mem[8] = enc_r(7'b0, 5'd8, 5'd9, 3'b001, 5'd16);
        for (int i = 0; i < 9; i++) expect_retire(32'(4 * i), 4 * (i + 1));
        release_reset();
        wait_drain(200);
        rd_reg(5'd10, 32'hFFFF_FFFE);
        rd_reg(5'd11, 32'd1);
        rd_reg(5'd12, 32'd0);
        rd_reg(5'd13, 32'd6);
        rd_reg(5'd14, 32'd7);
        rd_reg(5'd15, 32'd1);
        rd_reg(5'd16, 32'd96);

        // 3: LUI, arithmetic vs logical right shift, x0 write discarded
        hold_reset();
        mem[0] = enc_lui(20'h80000, 5'd1);
        mem[1] = enc_i(12'h404, 5'd1, 3'b101, 5'd2);
        mem[2] = enc_i(12'h004, 5'd1, 3'b101, 5'd3);
        mem[3] = enc_i(12'd1, 5'd0, 3'b000, 5'd0);
        for (int i = 0; i < 4; i++) expect_retire(32'(4 * i), 4 * (i + 1));
        release_reset();
        wait_drain(100);
        rd_reg(5'd1, 32'h8000_0000);
        rd_reg(5'd2, 32'hF800_0000);
        rd_reg(5'd3, 32'h0800_0000);
        rd_reg(5'd0, 32'd0);

        // 4: three wait states per fetch, 7 cycles per instruction
        hold_reset();
        delay = 3;
        load_t1();
        expect_retire(32'd0, 7);
        expect_retire(32'd4, 14);
        expect_retire(32'd8, 21);
        release_reset();
        wait_drain(100);
        rd_reg(5'd7, 32'd12);
        wait_cyc(30);
        chk("t4_halted", 32'(halted), 32'd1);
        hold_reset();
        delay = 0;

        // 5: all-zero word halts; NREGS=16 instance halts on x20
        mem[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1);
        expect_retire(32'd0, 4);
        release_reset();
        wait_cyc(6);
        chk("t5_halted_decode", 32'(halted), 32'd0);
        wait_cyc(7);
        chk("t5_halted", 32'(halted), 32'd1);
        chk("t5_req", 32'(imem_req), 32'd0);
        wait_cyc(12);
        chk("t5_req_late", 32'(imem_req), 32'd0);
        chk("t5_pc_frozen", imem_addr, 32'd4);
        chk("t5_halted_late", 32'(halted), 32'd1);
        rd_reg(5'd1, 32'd1);
        chk("rv16_halted", 32'(halted16), 32'd1);
        chk("rv16_req", 32'(req16), 32'd0);
        chk("rv16_pc", addr16, 32'd0);
        chk("rv16_rpc", rpc16, 32'd0);
        dbg16 = 4'd1;
        #1;
        chk("rv16_x1", dbgd16, 32'd0);
        wait_drain(10);

        // 6: reset during EXECUTE aborts the instruction
        hold_reset();
        mem[0] = enc_i(12'd9, 5'd0, 3'b000, 5'd5);
        release_reset();
        wait_cyc(3);
        reset = 1'b0;
        #1;
        chk("t6_req", 32'(imem_req), 32'd0);
        chk("t6_retire", 32'(retire), 32'd0);
        chk("t6_halted", 32'(halted), 32'd0);
        chk("t6_addr", imem_addr, 32'd0);
        rd_reg(5'd5, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        expect_retire(32'd0, 4);
        release_reset();
        @(negedge clk);
        chk("t6_restart_req", 32'(imem_req), 32'd1);
        chk("t6_restart_addr", imem_addr, 32'd0);
        wait_drain(50);
        rd_reg(5'd5, 32'd9);

`ifdef MULTICYCLE_CORE_BRANCH_EN
        // 7: taken backward branch returns fetch to PC 0
        hold_reset();
        mem[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1);
        mem[1] = enc_i(12'd2, 5'd0, 3'b000, 5'd2);
        mem[2] = enc_b(13'h1FF8, 5'd0, 5'd0, 3'b000);
        expect_retire(32'd0, 4);
        expect_retire(32'd4, 8);
        expect_retire(32'd8, 12);
        release_reset();
        wait_cyc(13);
        chk("br_target", imem_addr, 32'd0);
        chk("br_req", 32'(imem_req), 32'd1);
        chk("br_pending", 32'(exp_q.size()), 32'd0);
        hold_reset();
`else
        // 7: branch opcode is illegal without the branch option
        hold_reset();
        mem[0] = enc_b(13'd8, 5'd0, 5'd0, 3'b000);
        release_reset();
        wait_cyc(4);
        chk("br_illegal_halt", 32'(halted), 32'd1);
        chk("br_illegal_pc", imem_addr, 32'd0);
        hold_reset();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
